// File: rtl/phys_free_list_pkg.sv
// Shared rename-stage definitions for the physical register free list.
// Holds the register-file sizing, the physical tag type, the free-list
// pointer type and a 4-bit population count used for slot compaction.
package phys_free_list_pkg;

  localparam int NUM_PREG     = 64;
  localparam int NUM_AREG     = 32;
  localparam int PTAG_W       = 6;
  localparam int RENAME_WIDTH = 4;
  localparam int DEPTH        = NUM_PREG - NUM_AREG;
  localparam int IDX_W        = $clog2(DEPTH);
  // One extra wrap bit so that full (count=DEPTH) and empty (count=0) differ.
  localparam int PTR_W        = IDX_W + 1;

  typedef logic [PTAG_W-1:0] ptag_t;
  typedef logic [PTR_W-1:0]  ptr_t;

  function automatic logic [2:0] popcount4(input logic [3:0] m);
    return 3'(m[0]) + 3'(m[1]) + 3'(m[2]) + 3'(m[3]);
  endfunction

endpackage

// File: rtl/phys_free_list_slot_compact.sv
// Slot compaction helper: turns a 4-bit per-slot valid mask into the
// prefix offset of each slot (how many lower slots are valid) and the
// total number of valid slots.
// Ports:
//   vld_i        4-bit valid mask, bit i = slot i
//   off0_o..3_o  prefix offset of slot i (0..3)
//   total_o      popcount of vld_i (0..4)
module phys_free_list_slot_compact
  import phys_free_list_pkg::*;
(
  input  logic [3:0] vld_i,
  output logic [1:0] off0_o,
  output logic [1:0] off1_o,
  output logic [1:0] off2_o,
  output logic [1:0] off3_o,
  output logic [2:0] total_o
);

  assign off0_o  = 2'd0;
  assign off1_o  = {1'b0, vld_i[0]};
  assign off2_o  = 2'(popcount4({2'b00, vld_i[1:0]}));
  assign off3_o  = 2'(popcount4({1'b0, vld_i[2:0]}));
  assign total_o = popcount4(vld_i);

endmodule

// File: rtl/phys_free_list.sv
// Physical register free list for the 4-wide rename stage.
// Circular buffer of free physical tags with a speculative head (rename
// allocation), a committed head (retired allocations) and a tail (frees).
// Ports:
//   clk_i, rst_i              clock, asynchronous active-high reset
//   alloc_req_i[3:0]          slots needing a destination tag
//   alloc_vld_i               rename advances this cycle
//   alloc_rdy_o               enough free tags for the requested slots
//   alloc_tag0_o..3_o         compacted tag per requesting slot
//   free_vld_i[3:0]           retire slots releasing a tag
//   free_tag0_i..3_i          released tags
//   retire_alloc_cnt_i[2:0]   retiring instructions that had allocated
//   recover_i                 flush: roll speculative head back
//   free_cnt_o                number of free entries
//
// Handshake: allocation fires when alloc_vld_i & alloc_rdy_o & !recover_i.
// alloc_rdy_o depends only on registered state and alloc_req_i, never on
// alloc_vld_i or same-cycle frees; upstream holds its request while
// alloc_rdy_o is low. Frees have no ready and are always accepted.
module phys_free_list
  import phys_free_list_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [3:0]        alloc_req_i,
  input  logic              alloc_vld_i,
  output logic              alloc_rdy_o,
  output logic [PTAG_W-1:0] alloc_tag0_o,
  output logic [PTAG_W-1:0] alloc_tag1_o,
  output logic [PTAG_W-1:0] alloc_tag2_o,
  output logic [PTAG_W-1:0] alloc_tag3_o,
  input  logic [3:0]        free_vld_i,
  input  logic [PTAG_W-1:0] free_tag0_i,
  input  logic [PTAG_W-1:0] free_tag1_i,
  input  logic [PTAG_W-1:0] free_tag2_i,
  input  logic [PTAG_W-1:0] free_tag3_i,
  input  logic [2:0]        retire_alloc_cnt_i,
  input  logic              recover_i,
  output logic [PTR_W-1:0]  free_cnt_o
);

  ptag_t          entries_q [DEPTH];
  ptr_t           head_q, head_d;
  ptr_t           commit_head_q, commit_head_d;
  ptr_t           tail_q, tail_d;
  ptr_t           count;
  logic           alloc_fire;
  logic [1:0]     a_off [RENAME_WIDTH];
  logic [1:0]     f_off [RENAME_WIDTH];
  logic [2:0]     a_total, f_total;
  ptag_t          free_tag [RENAME_WIDTH];
  logic [IDX_W-1:0] rd_idx [RENAME_WIDTH];
  logic [IDX_W-1:0] wr_idx [RENAME_WIDTH];

  phys_free_list_slot_compact u_alloc_compact (
    .vld_i   (alloc_req_i),
    .off0_o  (a_off[0]),
    .off1_o  (a_off[1]),
    .off2_o  (a_off[2]),
    .off3_o  (a_off[3]),
    .total_o (a_total)
  );

  phys_free_list_slot_compact u_free_compact (
    .vld_i   (free_vld_i),
    .off0_o  (f_off[0]),
    .off1_o  (f_off[1]),
    .off2_o  (f_off[2]),
    .off3_o  (f_off[3]),
    .total_o (f_total)
  );

  assign free_tag[0] = free_tag0_i;
  assign free_tag[1] = free_tag1_i;
  assign free_tag[2] = free_tag2_i;
  assign free_tag[3] = free_tag3_i;

  // Index arithmetic is done on the low bits only so that a group of
  // four can straddle the end of the array naturally.
  always_comb begin
    for (int i = 0; i < RENAME_WIDTH; i++) begin
      rd_idx[i] = head_q[IDX_W-1:0] + IDX_W'(a_off[i]);
      wr_idx[i] = tail_q[IDX_W-1:0] + IDX_W'(f_off[i]);
    end
  end

  assign alloc_tag0_o = entries_q[rd_idx[0]];
  assign alloc_tag1_o = entries_q[rd_idx[1]];
  assign alloc_tag2_o = entries_q[rd_idx[2]];
  assign alloc_tag3_o = entries_q[rd_idx[3]];

  assign count       = tail_q - head_q;
  assign free_cnt_o  = count;
  assign alloc_rdy_o = (count >= PTR_W'(a_total));
  assign alloc_fire  = alloc_vld_i & alloc_rdy_o & ~recover_i;

  always_comb begin
    commit_head_d = commit_head_q + PTR_W'(retire_alloc_cnt_i);
    tail_d        = tail_q + PTR_W'(f_total);
    head_d        = head_q;
    // Recovery lands on the committed head including this cycle's retires.
    if (recover_i) begin
      head_d = commit_head_d;
    end else if (alloc_fire) begin
      head_d = head_q + PTR_W'(a_total);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_q        <= '0;
      commit_head_q <= '0;
      tail_q        <= PTR_W'(DEPTH);
    end else begin
      head_q        <= head_d;
      commit_head_q <= commit_head_d;
      tail_q        <= tail_d;
    end
  end

  // Frees within one cycle target distinct consecutive entries.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 0; k < DEPTH; k++) begin
        entries_q[k] <= ptag_t'(NUM_AREG + k);
      end
    end else begin
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        if (free_vld_i[i]) begin
          entries_q[wr_idx[i]] <= free_tag[i];
        end
      end
    end
  end

`ifndef SYNTHESIS
  always @(posedge clk_i) begin
    if (!rst_i) begin
      assert (count <= PTR_W'(DEPTH));
      assert ((int'(count) + int'(f_total)) <= DEPTH);
      assert (PTR_W'(head_q - commit_head_q) <= PTR_W'(DEPTH));
      // A freed tag must not already sit in the live region [head, tail).
      for (int i = 0; i < RENAME_WIDTH; i++) begin
        if (free_vld_i[i]) begin
          for (int k = 0; k < DEPTH; k++) begin
            assert (!(({1'b0, IDX_W'(IDX_W'(k) - head_q[IDX_W-1:0])} < count) &&
                      (entries_q[k] == free_tag[i])));
          end
        end
      end
    end
  end
`endif

endmodule

// File: tb/tb_phys_free_list.sv
module tb_phys_free_list;

  logic       clk_i;
  logic       rst_i;
  logic [3:0] alloc_req_i;
  logic       alloc_vld_i;
  logic       alloc_rdy_o;
  logic [5:0] alloc_tag0_o, alloc_tag1_o, alloc_tag2_o, alloc_tag3_o;
  logic [3:0] free_vld_i;
  logic [5:0] free_tag0_i, free_tag1_i, free_tag2_i, free_tag3_i;
  logic [2:0] retire_alloc_cnt_i;
  logic       recover_i;
  logic [5:0] free_cnt_o;
  logic [5:0] tag_o [4];

  int total;
  int bad;

  phys_free_list dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .alloc_req_i        (alloc_req_i),
    .alloc_vld_i        (alloc_vld_i),
    .alloc_rdy_o        (alloc_rdy_o),
    .alloc_tag0_o       (alloc_tag0_o),
    .alloc_tag1_o       (alloc_tag1_o),
    .alloc_tag2_o       (alloc_tag2_o),
    .alloc_tag3_o       (alloc_tag3_o),
    .free_vld_i         (free_vld_i),
    .free_tag0_i        (free_tag0_i),
    .free_tag1_i        (free_tag1_i),
    .free_tag2_i        (free_tag2_i),
    .free_tag3_i        (free_tag3_i),
    .retire_alloc_cnt_i (retire_alloc_cnt_i),
    .recover_i          (recover_i),
    .free_cnt_o         (free_cnt_o)
  );

  assign tag_o[0] = alloc_tag0_o;
  assign tag_o[1] = alloc_tag1_o;
  assign tag_o[2] = alloc_tag2_o;
  assign tag_o[3] = alloc_tag3_o;

  // clock / reset
  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  // driver tasks
  task automatic set_in(input logic [3:0] req, input logic vld, input logic [3:0] fvld,
                        input int ft0, input int ft1, input int ft2, input int ft3,
                        input int ret, input logic rec);
    alloc_req_i        = req;
    alloc_vld_i        = vld;
    free_vld_i         = fvld;
    free_tag0_i        = 6'(ft0);
    free_tag1_i        = 6'(ft1);
    free_tag2_i        = 6'(ft2);
    free_tag3_i        = 6'(ft3);
    retire_alloc_cnt_i = 3'(ret);
    recover_i          = rec;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    set_in(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    set_in(4'b1111, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    #1;
    total++;
    if (free_cnt_o !== 6'd32) begin
      $display("FAIL reset_cnt got=%0d exp=32", free_cnt_o); bad++;
    end
    total++;
    if (alloc_rdy_o !== 1'b1) begin
      $display("FAIL reset_rdy got=%0b exp=1", alloc_rdy_o); bad++;
    end
    for (int s = 0; s < 4; s++) begin
      total++;
      if (tag_o[s] !== 6'(32 + s)) begin
        $display("FAIL reset_tag%0d got=%0d exp=%0d", s, tag_o[s], 32 + s); bad++;
      end
    end
  endtask

  task automatic test_drain();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_in(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
      #1;
      total++;
      if (alloc_rdy_o !== 1'b1) begin
        $display("FAIL drain_rdy c=%0d got=%0b exp=1", c, alloc_rdy_o); bad++;
      end
      for (int s = 0; s < 4; s++) begin
        total++;
        if (tag_o[s] !== 6'(32 + 4 * c + s)) begin
          $display("FAIL drain_tag c=%0d s=%0d got=%0d exp=%0d", c, s, tag_o[s], 32 + 4 * c + s); bad++;
        end
      end
      step();
    end
    set_in(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    #1;
    total++;
    if (free_cnt_o !== 6'd0) begin
      $display("FAIL drain_empty_cnt got=%0d exp=0", free_cnt_o); bad++;
    end
    total++;
    if (alloc_rdy_o !== 1'b1) begin
      $display("FAIL empty_zero_req_rdy got=%0b exp=1", alloc_rdy_o); bad++;
    end
    set_in(4'b0001, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    #1;
    total++;
    if (alloc_rdy_o !== 1'b0) begin
      $display("FAIL empty_rdy got=%0b exp=0", alloc_rdy_o); bad++;
    end
    step();
    total++;
    if (free_cnt_o !== 6'd0) begin
      $display("FAIL empty_hold_cnt got=%0d exp=0", free_cnt_o); bad++;
    end
  endtask

  task automatic test_free_no_bypass();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      set_in(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 4, 1'b0);
      step();
    end
    set_in(4'b0001, 1'b1, 4'b0101, 40, 0, 41, 0, 0, 1'b0);
    #1;
    total++;
    if (alloc_rdy_o !== 1'b0) begin
      $display("FAIL nobypass_rdy got=%0b exp=0", alloc_rdy_o); bad++;
    end
    step();
    set_in(4'b0001, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    #1;
    total++;
    if (alloc_rdy_o !== 1'b1) begin
      $display("FAIL after_free_rdy got=%0b exp=1", alloc_rdy_o); bad++;
    end
    total++;
    if (alloc_tag0_o !== 6'd40) begin
      $display("FAIL after_free_tag0 got=%0d exp=40", alloc_tag0_o); bad++;
    end
    total++;
    if (free_cnt_o !== 6'd2) begin
      $display("FAIL after_free_cnt got=%0d exp=2", free_cnt_o); bad++;
    end
  endtask

  task automatic test_sparse();
    do_reset();
    set_in(4'b1010, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    #1;
    total++;
    if (alloc_tag1_o !== 6'd32) begin
      $display("FAIL sparse_tag1 got=%0d exp=32", alloc_tag1_o); bad++;
    end
    total++;
    if (alloc_tag3_o !== 6'd33) begin
      $display("FAIL sparse_tag3 got=%0d exp=33", alloc_tag3_o); bad++;
    end
    step();
    set_in(4'b0001, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    #1;
    total++;
    if (free_cnt_o !== 6'd30) begin
      $display("FAIL sparse_cnt got=%0d exp=30", free_cnt_o); bad++;
    end
    total++;
    if (alloc_tag0_o !== 6'd34) begin
      $display("FAIL sparse_next_tag0 got=%0d exp=34", alloc_tag0_o); bad++;
    end
  endtask

  task automatic test_recover();
    do_reset();
    set_in(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    step();
    set_in(4'b0011, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    step();
    set_in(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 2, 1'b0);
    step();
    set_in(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 1, 1'b1);
    step();
    set_in(4'b0011, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    #1;
    total++;
    if (free_cnt_o !== 6'd29) begin
      $display("FAIL recover_cnt got=%0d exp=29", free_cnt_o); bad++;
    end
    total++;
    if (alloc_tag0_o !== 6'd35) begin
      $display("FAIL recover_tag0 got=%0d exp=35", alloc_tag0_o); bad++;
    end
    total++;
    if (alloc_tag1_o !== 6'd36) begin
      $display("FAIL recover_tag1 got=%0d exp=36", alloc_tag1_o); bad++;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    // drain all 32, committing as we go
    for (int c = 0; c < 8; c++) begin
      set_in(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 4, 1'b0);
      step();
    end
    // return 30 of them: tail index moves to 30
    for (int c = 0; c < 7; c++) begin
      set_in(4'b0000, 1'b0, 4'b1111, 32 + 4 * c, 33 + 4 * c, 34 + 4 * c, 35 + 4 * c, 0, 1'b0);
      step();
    end
    set_in(4'b0000, 1'b0, 4'b0011, 60, 61, 0, 0, 0, 1'b0);
    step();
    total++;
    if (free_cnt_o !== 6'd30) begin
      $display("FAIL wrap_refill_cnt got=%0d exp=30", free_cnt_o); bad++;
    end
    // reallocate 30: head index moves to 30
    for (int c = 0; c < 7; c++) begin
      set_in(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 4, 1'b0);
      #1;
      total++;
      if (alloc_tag0_o !== 6'(32 + 4 * c)) begin
        $display("FAIL wrap_realloc_tag0 c=%0d got=%0d exp=%0d", c, alloc_tag0_o, 32 + 4 * c); bad++;
      end
      step();
    end
    set_in(4'b0011, 1'b1, 4'b0000, 0, 0, 0, 0, 2, 1'b0);
    step();
    total++;
    if (free_cnt_o !== 6'd0) begin
      $display("FAIL wrap_empty_cnt got=%0d exp=0", free_cnt_o); bad++;
    end
    // four frees straddle the array end: entries 30,31,0,1
    set_in(4'b0000, 1'b0, 4'b1111, 1, 2, 3, 4, 0, 1'b0);
    step();
    set_in(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    #1;
    total++;
    if (free_cnt_o !== 6'd4) begin
      $display("FAIL wrap_free_cnt got=%0d exp=4", free_cnt_o); bad++;
    end
    total++;
    if (alloc_rdy_o !== 1'b1) begin
      $display("FAIL wrap_rdy got=%0b exp=1", alloc_rdy_o); bad++;
    end
    for (int s = 0; s < 4; s++) begin
      total++;
      if (tag_o[s] !== 6'(1 + s)) begin
        $display("FAIL wrap_tag%0d got=%0d exp=%0d", s, tag_o[s], 1 + s); bad++;
      end
    end
    step();
    set_in(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    #1;
    total++;
    if (free_cnt_o !== 6'd0) begin
      $display("FAIL wrap_final_cnt got=%0d exp=0", free_cnt_o); bad++;
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    set_in(4'b1111, 1'b1, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    step();
    #1;
    total++;
    if (alloc_tag0_o !== 6'd36) begin
      $display("FAIL pre_reset_tag0 got=%0d exp=36", alloc_tag0_o); bad++;
    end
    #2;
    rst_i = 1'b1;
    #1;
    total++;
    if (free_cnt_o !== 6'd32) begin
      $display("FAIL async_cnt got=%0d exp=32", free_cnt_o); bad++;
    end
    total++;
    if (alloc_rdy_o !== 1'b1) begin
      $display("FAIL async_rdy got=%0b exp=1", alloc_rdy_o); bad++;
    end
    for (int s = 0; s < 4; s++) begin
      total++;
      if (tag_o[s] !== 6'(32 + s)) begin
        $display("FAIL async_tag%0d got=%0d exp=%0d", s, tag_o[s], 32 + s); bad++;
      end
    end
    set_in(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    step();
    rst_i = 1'b0;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_i = 1'b1;
    set_in(4'b0000, 1'b0, 4'b0000, 0, 0, 0, 0, 0, 1'b0);
    test_reset();
    test_drain();
    test_free_no_bypass();
    test_sparse();
    test_recover();
    test_wrap();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
